// File: rtl/seg7_pkg.sv
// Shared segment encodings and window geometry for the multiplexed BCD display.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_ERR   = 7'h06;

    localparam int OFFSET_MAX = 2;
    localparam int NUM_DIGITS = 4;

    // Active-low {g,f,e,d,c,b,a} patterns; element [0] is the glyph for 0.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        OFS_0 = 2'd0,
        OFS_1 = 2'd1,
        OFS_2 = 2'd2
    } offset_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph; non-decimal nibbles show 'E'.
module bcd_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    // Table lookup for decimal digits, error glyph otherwise.
    always_comb begin
        seg = SEG_ERR;
        if (nibble <= 4'd9) begin
            seg = SEG_DIGITS[nibble];
        end else begin
            seg = SEG_ERR;
        end
    end

endmodule

// File: rtl/bcd_seven_seg_display.sv
// Time-multiplexed 4-digit window over a sign + 5-digit BCD buffer, scrollable.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros in pos4..pos1.
module bcd_seven_seg_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] bcd_in,
    input  logic        sign_in,
    input  logic        load,
    input  logic        scroll_left,
    input  logic        scroll_right,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n
);
    import seg7_pkg::*;

    localparam int              DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic [1:0]       idx_r;
    offset_e          ofs_r;
    logic [19:0]      bcd_r;
    logic             sign_r;

    logic             wrap_s;
    logic [1:0]       ofs_val_s;
    logic [2:0]       pos_s;
    logic [3:0]       nibble_s;
    logic             blank_s;
    logic [4:0]       lz_s;
    logic [6:0]       dec_seg_s;
    logic [6:0]       seg_sel_s;

    assign wrap_s    = (div_cnt_r == DIV_LAST);
    assign ofs_val_s = ofs_r;
    assign pos_s     = {1'b0, idx_r} + {1'b0, ofs_val_s};

`ifdef LEADING_ZERO_BLANK_EN
    logic [4:0] zero_s;

    assign zero_s[0] = (bcd_r[3:0]   == 4'd0);
    assign zero_s[1] = (bcd_r[7:4]   == 4'd0);
    assign zero_s[2] = (bcd_r[11:8]  == 4'd0);
    assign zero_s[3] = (bcd_r[15:12] == 4'd0);
    assign zero_s[4] = (bcd_r[19:16] == 4'd0);
    // A position is a leading zero when it and every position above it is zero.
    assign lz_s = {zero_s[4],
                   zero_s[4] & zero_s[3],
                   zero_s[4] & zero_s[3] & zero_s[2],
                   zero_s[4] & zero_s[3] & zero_s[2] & zero_s[1],
                   1'b0};
`else
    assign lz_s = 5'b00000;
`endif

    // Refresh divider and digit-slot index.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= '0;
            idx_r     <= 2'd0;
        end else if (wrap_s) begin
            div_cnt_r <= '0;
            idx_r     <= idx_r + 2'd1;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
            idx_r     <= idx_r;
        end
    end

    // Window offset FSM; opposing pulses in one cycle cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            ofs_r <= OFS_0;
        end else if (scroll_left && !scroll_right) begin
            case (ofs_r)
                OFS_0:   ofs_r <= OFS_1;
                OFS_1:   ofs_r <= OFS_2;
                OFS_2:   ofs_r <= OFS_2;
                default: ofs_r <= OFS_0;
            endcase
        end else if (scroll_right && !scroll_left) begin
            case (ofs_r)
                OFS_0:   ofs_r <= OFS_0;
                OFS_1:   ofs_r <= OFS_0;
                OFS_2:   ofs_r <= OFS_1;
                default: ofs_r <= OFS_0;
            endcase
        end else begin
            ofs_r <= ofs_r;
        end
    end

    // Display buffer capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_r  <= 20'h00000;
            sign_r <= 1'b0;
        end else if (load) begin
            bcd_r  <= bcd_in;
            sign_r <= sign_in;
        end else begin
            bcd_r  <= bcd_r;
            sign_r <= sign_r;
        end
    end

    // Select the buffer position shown in the current slot.
    always_comb begin
        nibble_s = 4'd0;
        blank_s  = 1'b0;
        case (pos_s)
            3'd0: begin nibble_s = bcd_r[3:0];   blank_s = lz_s[0]; end
            3'd1: begin nibble_s = bcd_r[7:4];   blank_s = lz_s[1]; end
            3'd2: begin nibble_s = bcd_r[11:8];  blank_s = lz_s[2]; end
            3'd3: begin nibble_s = bcd_r[15:12]; blank_s = lz_s[3]; end
            3'd4: begin nibble_s = bcd_r[19:16]; blank_s = lz_s[4]; end
            default: begin nibble_s = 4'd0;      blank_s = 1'b1;    end
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble (nibble_s),
        .seg    (dec_seg_s)
    );

    // Final glyph: sign slot, blanked leading zero, or decoded digit.
    always_comb begin
        seg_sel_s = SEG_BLANK;
        if (pos_s == 3'd5) begin
            seg_sel_s = sign_r ? SEG_MINUS : SEG_BLANK;
        end else if (blank_s) begin
            seg_sel_s = SEG_BLANK;
        end else begin
            seg_sel_s = dec_seg_s;
        end
    end

    // Registered pin drivers; dp marks that low-order digits are scrolled off.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_n  <= 4'hF;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= ~(4'b0001 << idx_r);
            seg_n <= seg_sel_s;
            dp_n  <= ~((idx_r == 2'd0) && (ofs_r != OFS_0));
        end
    end

endmodule
